// File: rtl/tl_pkg.sv
// tl_pkg: lamp codes and sequencer state encoding shared by the traffic-light blocks
package tl_pkg;
  typedef logic [1:0] lamp_t;
  localparam lamp_t RED    = 2'b00;
  localparam lamp_t YELLOW = 2'b01;
  localparam lamp_t GREEN  = 2'b10;
  localparam lamp_t OFF    = 2'b11;
  typedef enum logic [1:0] {S_CLEAR, S_GREEN, S_YELLOW, S_FLASH} tl_state_t;
endpackage

// File: rtl/tl_interval_timer.sv
// tl_interval_timer: loadable down-counter stepped by tick_en; expire covers 1 and the defensive 0
module tl_interval_timer #(
  parameter int TIME_W  = 5,
  parameter int RST_VAL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              tick_en,
  output logic [TIME_W-1:0] remain,
  output logic              expire
);
  logic [TIME_W-1:0] remain_q, remain_d;
  always_comb remain_d = load ? load_val : tick_en ? remain_q - 1'b1 : remain_q;
  always_ff @(posedge clk)
    if (!rst_n) remain_q <= TIME_W'(RST_VAL);
    else        remain_q <= remain_d;
  assign remain = remain_q;
  assign expire = remain_q <= TIME_W'(1);
endmodule

// File: rtl/tl_phase_sequencer.sv
// tl_phase_sequencer: rotates GREEN/YELLOW/all-red CLEAR across approaches on a shared 1 s tick,
// with peak-hour green and a flashing-yellow override.
module tl_phase_sequencer
  import tl_pkg::*;
#(
  parameter int NUM_PHASES   = 2,
  parameter int TIME_W       = 5,
  parameter int GREEN_T      = 16,
  parameter int GREEN_PEAK_T = 8,
  parameter int YELLOW_T     = 5,
  parameter int CLEAR_T      = 2,
  parameter int PH_W         = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    enb,
  input  logic                    peak,
  input  logic                    flash_req,
  output logic [2*NUM_PHASES-1:0] light,
  output logic [TIME_W-1:0]       remain,
  output logic [PH_W-1:0]         active_phase,
  output logic                    step,
  output logic                    flashing
);
  localparam int TMAX = (1 << TIME_W) - 1;
  if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_phases
    $fatal(1, "NUM_PHASES must be in 2..8");
  end
  if (GREEN_T < 1 || GREEN_T > TMAX || GREEN_PEAK_T < 1 || GREEN_PEAK_T > TMAX ||
      YELLOW_T < 1 || YELLOW_T > TMAX || CLEAR_T < 1 || CLEAR_T > TMAX) begin : g_bad_times
    $fatal(1, "interval durations must fit 1..2^TIME_W-1");
  end
  tl_state_t state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic blink_q, blink_d, step_q, step_d, flashing_q;
  logic [2*NUM_PHASES-1:0] light_q, light_d;
  logic load, expire, ev;
  logic [TIME_W-1:0] load_val;
  assign ev = tick & enb;
  tl_interval_timer #(.TIME_W(TIME_W), .RST_VAL(CLEAR_T)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .tick_en(ev & ~load), .remain(remain), .expire(expire)
  );
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    blink_d  = blink_q;
    step_d   = 1'b0;
    load     = 1'b0;
    load_val = '0;
    if (ev && state_q != S_FLASH && flash_req) begin
      state_d = S_FLASH;
      blink_d = 1'b1;
      load    = 1'b1;
      step_d  = 1'b1;
    end else if (ev && state_q == S_FLASH) begin
      // FLASH parks the timer at 0; leaving reloads the clearance interval
      load = 1'b1;
      if (flash_req) blink_d = ~blink_q;
      else begin
        state_d  = S_CLEAR;
        load_val = TIME_W'(CLEAR_T);
        step_d   = 1'b1;
      end
    end else if (ev && expire) begin
      load   = 1'b1;
      step_d = 1'b1;
      if (state_q == S_GREEN) begin
        state_d  = S_YELLOW;
        load_val = TIME_W'(YELLOW_T);
      end else if (state_q == S_YELLOW) begin
        state_d  = S_CLEAR;
        load_val = TIME_W'(CLEAR_T);
      end else begin
        state_d  = S_GREEN;
        phase_d  = (phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;
        load_val = peak ? TIME_W'(GREEN_PEAK_T) : TIME_W'(GREEN_T);
      end
    end
  end
  always_comb begin
    light_d = '0;
    for (int i = 0; i < NUM_PHASES; i++)
      light_d[2*i +: 2] = (state_d == S_FLASH) ? (blink_d ? YELLOW : OFF) :
                          (PH_W'(i) != phase_d) ? RED :
                          (state_d == S_GREEN) ? GREEN :
                          (state_d == S_YELLOW) ? YELLOW : RED;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      phase_q    <= PH_W'(NUM_PHASES - 1);
      blink_q    <= 1'b0;
      step_q     <= 1'b0;
      flashing_q <= 1'b0;
      light_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      blink_q    <= blink_d;
      step_q     <= step_d;
      flashing_q <= state_d == S_FLASH;
      light_q    <= light_d;
    end
  assign light        = light_q;
  assign active_phase = phase_q;
  assign step         = step_q;
  assign flashing     = flashing_q;
endmodule

// File: tb/tb_tl_phase_sequencer.sv
// tb_tl_phase_sequencer: random stimulus against a behavioural model, checked through a scoreboard queue
module tb_tl_phase_sequencer;
  localparam int N = 3, TW = 5;
  logic clk = 1'b0, rst_n, tick, enb, peak, flash_req;
  logic [2*N-1:0] light;
  logic [TW-1:0] remain;
  logic [1:0] active_phase;
  logic step, flashing;
  typedef struct {
    logic [31:0] light, remain, ph, step, fl;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  bit m_flash, m_blink, m_step;
  int m_rem, m_ph;
  string m_iv;
  always #5 clk = ~clk;
  tl_phase_sequencer #(.NUM_PHASES(N), .TIME_W(TW), .GREEN_T(16), .GREEN_PEAK_T(8),
                       .YELLOW_T(5), .CLEAR_T(2)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enb(enb), .peak(peak), .flash_req(flash_req),
    .light(light), .remain(remain), .active_phase(active_phase), .step(step), .flashing(flashing)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, want);
    end
  endtask
  // Model: which interval is running ("green"/"yellow"/"clear") or flash, with ticks left
  task automatic model_edge(input bit r, input bit t, input bit e, input bit p, input bit f);
    exp_t x;
    m_step = 0;
    if (!r) begin
      m_flash = 0; m_iv = "clear"; m_rem = 2; m_ph = N - 1;
    end else if (t && e) begin
      if (!m_flash && f) begin
        m_flash = 1; m_blink = 1; m_rem = 0; m_step = 1;
      end else if (m_flash) begin
        if (f) m_blink = !m_blink;
        else begin m_flash = 0; m_iv = "clear"; m_rem = 2; m_step = 1; end
      end else if (m_rem > 1) m_rem = m_rem - 1;
      else begin
        m_step = 1;
        if (m_iv == "green") begin m_iv = "yellow"; m_rem = 5; end
        else if (m_iv == "yellow") begin m_iv = "clear"; m_rem = 2; end
        else begin m_iv = "green"; m_ph = (m_ph + 1) % N; m_rem = p ? 8 : 16; end
      end
    end
    x.light = 0;
    for (int i = 0; i < N; i++) begin
      int code;
      if (m_flash) code = m_blink ? 1 : 3;
      else if (i != m_ph) code = 0;
      else code = (m_iv == "green") ? 2 : (m_iv == "yellow") ? 1 : 0;
      x.light = x.light | (code << (2 * i));
    end
    x.remain = m_rem;
    x.ph = m_ph;
    x.step = m_step;
    x.fl = m_flash;
    q.push_back(x);
  endtask
  always begin
    exp_t x;
    int lit;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("light", 32'(light), x.light);
      chk("remain", 32'(remain), x.remain);
      chk("active_phase", 32'(active_phase), x.ph);
      chk("step", 32'(step), x.step);
      chk("flashing", 32'(flashing), x.fl);
      if (!flashing) begin
        lit = 0;
        for (int i = 0; i < N; i++) lit += (light[2*i +: 2] != 2'b00) ? 1 : 0;
        chk("one_non_red", 32'(lit <= 1), 32'd1);
      end
    end
  end
  initial begin
    bit fl_s;
    fl_s = 0;
    rst_n = 0; tick = 0; enb = 1; peak = 0; flash_req = 0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      rst_n = (c < 3) ? 1'b0 : ($urandom_range(0, 499) != 0);
      tick = (c < 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
      enb = ($urandom_range(0, 9) != 0);
      peak = $urandom_range(0, 1);
      if ($urandom_range(0, 59) == 0) fl_s = !fl_s;
      flash_req = fl_s;
      model_edge(rst_n, tick, enb, peak, flash_req);
    end
    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tl_phase_sequencer.md
Name: tl_phase_sequencer

Overview:
Parametrised multi-approach traffic-light phase sequencer for the intersection controller. It rotates right-of-way across NUM_PHASES approaches in the order GREEN, then YELLOW, then all-red CLEAR. It adds a peak-hour green time and a flashing-yellow fault/night mode. Timing advances on a shared 1 s tick pulse from the top-level divider, not on a per-block divider.

Parameters:
NUM_PHASES, 2, number of approaches sequenced (2..8)
TIME_W, 5, width of the remaining-time counter
GREEN_T, 16, green duration in ticks (normal)
GREEN_PEAK_T, 8, green duration in ticks when peak sampled high
YELLOW_T, 5, yellow duration in ticks
CLEAR_T, 2, all-red clearance duration in ticks
PH_W, $clog2(NUM_PHASES) (min 1), width of the phase index

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tick  in  1  one-clk pulse per second; the only time base
enb  in  1  run enable; low freezes the sequence
peak  in  1  peak-hour select; sampled only when a green is loaded
flash_req  in  1  request flashing-yellow mode; sampled on tick
light  out  2*NUM_PHASES  per-phase lamp code; phase i occupies bits [2i+1:2i]
remain  out  TIME_W  ticks left in the current interval
active_phase  out  PH_W  phase currently holding (or last held) right-of-way
step  out  1  one-clk pulse on every interval transition
flashing  out  1  high while in FLASH

Behaviour:
- Lamp codes: RED=00, YELLOW=01, GREEN=10, OFF=11.
- All outputs are registered. An event takes effect on the clk edge that samples tick=1 with enb=1; latency is 0 cycles after that edge.
- Reset (rst_n=0 at a clk edge, regardless of tick/enb):
  - state=CLEAR, remain=CLEAR_T, active_phase=NUM_PHASES-1.
  - All lights RED; step=0; flashing=0.
  - Result: the first green after reset goes to phase 0.
- States: CLEAR, GREEN, YELLOW, FLASH.
  - CLEAR: all phases RED.
  - GREEN: active_phase=GREEN, all others RED.
  - YELLOW: active_phase=YELLOW, all others RED.
  - At most one phase is non-RED outside FLASH. This is an invariant.
- Counting (tick=1, enb=1, no flash action):
  - If remain>1: remain decrements by 1.
  - If remain==1: transition, load the new interval, pulse step.
- Transitions on expiry:
  - GREEN -> YELLOW, remain=YELLOW_T.
  - YELLOW -> CLEAR, remain=CLEAR_T.
  - CLEAR -> GREEN: active_phase increments, wrapping NUM_PHASES-1 -> 0. remain=GREEN_PEAK_T if peak=1 at that edge, else GREEN_T.
- peak changing mid-green does not alter remain.
- remain==0 is never reached in normal operation. If it is seen (defensive), treat it as expiry.
- enb=0: tick is ignored; state, remain and light hold; step stays 0. flash_req is also ignored.
- Entering FLASH:
  - Condition: tick=1, enb=1, flash_req=1, in any non-FLASH state. This has priority over counting.
  - Action: enter FLASH, flashing=1, all phases YELLOW, remain=0, step pulses.
- In FLASH:
  - Each tick toggles all phases YELLOW <-> OFF together.
  - active_phase holds.
- Leaving FLASH:
  - Condition: tick=1, enb=1, flash_req=0.
  - Action: enter CLEAR with remain=CLEAR_T, all RED, flashing=0, step pulses. Sequencing resumes with phase active_phase+1.
- step is high for exactly one clk per transition and never on a plain decrement.
- Elaboration checks: every *_T must be in 1..2^TIME_W-1, and NUM_PHASES>=2. Violations are a fatal elaboration error.

Decomposition:
- Shared package tl_pkg:
  - Lamp-code constants RED, YELLOW, GREEN, OFF (2-bit typedef lamp_t).
  - State enum tl_state_t {CLEAR, GREEN, YELLOW, FLASH}.
- Optional sub-module tl_interval_timer:
  - Loadable down-counter with tick enable and expiry flag.
  - Parameter TIME_W; ports load, load_val, tick_en, remain, expire.
- The FSM and light decode stay in tl_phase_sequencer.

Test Plan:
1. Reset, NUM_PHASES=2: hold rst_n=0 for 3 clks -> light=4'b0000, remain=2, active_phase=1, step=0. After 2 ticks -> phase0 GREEN, remain=16, active_phase=0, step pulse.
2. Full rotation, N=3, peak=0:
   - Count ticks from phase0 green.
   - Ticks 16 -> YELLOW, remain 5. Tick 21 -> CLEAR, remain 2. Tick 23 -> phase1 GREEN.
   - After phase2, wrap to phase0.
   - Assert at most one non-RED phase every cycle.
3. Peak: peak=1 at CLEAR expiry -> remain=8. Drop peak at remain=4 -> green still ends 4 ticks later.
4. enb freeze: enb=0 at remain=10 for 50 ticks -> remain=10, light unchanged, step=0. Re-enable -> next tick remain=9.
5. Flash:
   - flash_req=1 mid-GREEN at remain=7 -> all YELLOW, flashing=1, step pulse. Next 3 ticks -> OFF, YELLOW, OFF.
   - flash_req=0 -> CLEAR with remain=2, then next phase GREEN.
6. Reset mid-operation in YELLOW with tick=1 on the same edge -> reset wins; state matches scenario 1 values.
